pc_sequencer: RTL
=================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL have parameter TRAP_VECTOR, default 32'h0000_0010, PC loaded on trap (PC_TRAP_EN only).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  decode/execute hold; freezes PC and fetch.
REQ-006 branch_valid  input  1  taken branch/jump resolved this cycle.
REQ-007 branch_target  input  32  redirect address.
REQ-008 imem_ack  input  1  instruction memory accepted/returned the current request.
REQ-009 imem_req  output  1  fetch request for pc_out.
REQ-010 pc_out  output  32  current fetch PC.
REQ-011 if_valid  output  1  one-cycle pulse: instruction at pc_out delivered and not flushed.
REQ-012 flush  output  1  one-cycle pulse: younger in-flight instructions are discarded.
REQ-013 trap  input  1  and  epc  output  32 (PC_TRAP_EN only): trap request / saved PC.

Function
REQ-014 SHALL implement the FSM IDLE, FETCH, HOLD, REDIRECT.
REQ-015 IDLE: one cycle after reset, imem_req=0, then FETCH.
REQ-016 FETCH: imem_req=1; on imem_ack with no redirect and no stall: if_valid=1 and pc_out += 4 the next cycle; without imem_ack: pc_out holds and the FSM stays in FETCH.
REQ-017 Stall in FETCH: imem_req=0 that cycle and an ack is ignored, go HOLD; HOLD holds pc_out, returns to FETCH the cycle stall deasserts.
REQ-018 branch_valid in FETCH or HOLD: pc_out <= {branch_target[31:2],2'b00} next cycle, flush=1 that cycle, if_valid=0 even if imem_ack=1, go REDIRECT.
REQ-019 REDIRECT: one bubble cycle, imem_req=0, then FETCH at new pc_out.
REQ-020 Priority for simultaneous events: rst > trap > branch_valid > stall > sequential advance.
REQ-021 branch_valid in REDIRECT or IDLE SHALL be accepted identically (newest redirect wins).
REQ-022 PC arithmetic is unsigned 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no error flag.
REQ-023 pc_out[1:0] SHALL always be 2'b00.
REQ-024 Outputs SHALL be registered or decoded only from state; no combinational path from imem_ack to imem_req.

Reset
REQ-025 With rst=1 at a clock edge: pc_out=RESET_VECTOR, state=IDLE, imem_req=0, if_valid=0, flush=0, epc=0 the next cycle.
REQ-026 Reset mid-fetch SHALL discard the outstanding request; an ack on the reset cycle is ignored.

Configuration
REQ-027 Macro PC_SEQUENCER_TRAP_EN: when defined, trap/epc exist; trap at any non-reset cycle: epc <= pc_out, pc_out <= TRAP_VECTOR, flush=1, go REDIRECT.
REQ-028 Without PC_SEQUENCER_TRAP_EN: no trap/epc ports, no epc register, behaviour otherwise identical.

Structure
REQ-029 Shared package nq_pc_pkg SHALL hold the FSM state typedef, PC_WIDTH=32, PC_STEP=4, default vectors.
REQ-030 One combinational sub-module pc_next_sel SHALL compute next PC from priority inputs; the FSM and registers stay in pc_sequencer.

Verification
REQ-031 Reset, ack held 1, no stall -> pc_out 0,0,4,8,C on successive cycles after IDLE; if_valid pulses at 0,4,8.
REQ-032 Ack withheld 3 cycles at pc_out=8 -> pc_out stays 8, imem_req=1, if_valid=0; ack -> pc_out=C next cycle.
REQ-033 stall 2 cycles at pc_out=4 with ack=1 -> imem_req=0, if_valid=0, pc_out=4 held; resumes FETCH at 4.
REQ-034 branch_valid with target 32'h0000_0103 plus simultaneous ack and stall -> flush=1, if_valid=0, one bubble, then fetch at 32'h0000_0100.
REQ-035 pc_out=32'hFFFF_FFFC, ack -> pc_out=0; rst asserted mid-HOLD -> pc_out=RESET_VECTOR, IDLE.
REQ-036 With PC_SEQUENCER_TRAP_EN: trap and branch_valid together at pc_out=20 -> epc=20, pc_out=32'h10, branch ignored.

Source files
------------

// File: rtl/nq_pc_pkg.sv
// rtl/nq_pc_pkg.sv - shared types and constants for the PC sequencer
// Purpose: FSM state encoding, PC width/step, default reset/trap vectors and
//          the word-alignment helper used by pc_sequencer and pc_next_sel.
package nq_pc_pkg;

    localparam int               PC_WIDTH             = 32;
    localparam logic [31:0]      PC_STEP              = 32'd4;
    localparam logic [31:0]      DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0]      DEFAULT_TRAP_VECTOR  = 32'h0000_0010;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_HOLD     = 2'd2,
        ST_REDIRECT = 2'd3
    } pc_state_e;

    // Every PC the sequencer ever holds is word aligned.
    function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] addr);
        return {addr[PC_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// rtl/pc_next_sel.sv - combinational next-PC selector
// Purpose: picks the next PC from the already-qualified events, highest
//          priority first: trap, branch redirect, sequential advance, hold.
// Ports:
//   trap_take_i     trap accepted this cycle (tied low when traps are absent)
//   branch_take_i   branch redirect accepted this cycle
//   advance_i       fetch delivered, step to the next word
//   pc_cur_i        current PC
//   branch_target_i redirect address (low bits dropped)
//   pc_next_o       PC for the next cycle
module pc_next_sel
    import nq_pc_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
    input  logic                trap_take_i,
    input  logic                branch_take_i,
    input  logic                advance_i,
    input  logic [PC_WIDTH-1:0] pc_cur_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    output logic [PC_WIDTH-1:0] pc_next_o
);

    always_comb begin
        pc_next_o = pc_cur_i;
        if (trap_take_i) begin
            pc_next_o = align_pc(TRAP_VECTOR);
        end else if (branch_take_i) begin
            pc_next_o = align_pc(branch_target_i);
        end else if (advance_i) begin
            // Plain modulo-2^32 wrap, no overflow indication.
            pc_next_o = pc_cur_i + PC_STEP;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction fetch PC sequencer (IDLE/FETCH/HOLD/REDIRECT)
// Purpose: drives the fetch PC and request, advances on memory ack, holds on
//          stall, redirects on branch (and on trap when PC_SEQUENCER_TRAP_EN
//          is defined, which adds the trap input and epc output).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   stall           pipeline hold; freezes PC and fetch
//   branch_valid    taken branch this cycle, branch_target is the destination
//   imem_ack        memory accepted/returned the current request
//   imem_req        fetch request for pc_out
//   pc_out          current fetch PC
//   if_valid        instruction at pc_out delivered this cycle
//   flush           younger in-flight instructions are discarded this cycle
//   trap, epc       (PC_SEQUENCER_TRAP_EN) trap request / saved PC
module pc_sequencer
    import nq_pc_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [PC_WIDTH-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_valid,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                imem_ack,
`ifdef PC_SEQUENCER_TRAP_EN
    input  logic                trap,
    output logic [PC_WIDTH-1:0] epc,
`endif
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic                if_valid,
    output logic                flush
);

    pc_state_e             state_q, state_d;
    logic [PC_WIDTH-1:0]   pc_q, pc_d;
    logic                  trap_take;
    logic                  branch_take;
    logic                  advance;

`ifdef PC_SEQUENCER_TRAP_EN
    logic [PC_WIDTH-1:0]   epc_q;
    assign trap_take = trap & ~rst;
    assign epc       = epc_q;
`else
    assign trap_take = 1'b0;
`endif

    // Branches are honoured in every state; trap outranks them.
    assign branch_take = branch_valid & ~rst & ~trap_take;

    // Request depends on state and stall only; the ack never feeds back here.
    assign imem_req = (state_q == ST_FETCH) & ~stall & ~rst;
    assign advance  = imem_req & imem_ack & ~branch_take & ~trap_take;
    assign if_valid = advance;
    assign flush    = trap_take | branch_take;
    assign pc_out   = pc_q;

    pc_next_sel #(
        .TRAP_VECTOR     (TRAP_VECTOR)
    ) u_pc_next_sel (
        .trap_take_i     (trap_take),
        .branch_take_i   (branch_take),
        .advance_i       (advance),
        .pc_cur_i        (pc_q),
        .branch_target_i (branch_target),
        .pc_next_o       (pc_d)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     state_d = ST_FETCH;
            ST_FETCH:    if (stall) state_d = ST_HOLD;
            ST_HOLD:     if (!stall) state_d = ST_FETCH;
            ST_REDIRECT: state_d = ST_FETCH;
            default:     state_d = ST_IDLE;
        endcase
        if (trap_take || branch_take) begin
            state_d = ST_REDIRECT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= align_pc(RESET_VECTOR);
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_SEQUENCER_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            epc_q <= '0;
        end else if (trap_take) begin
            epc_q <= pc_q;
        end
    end
`endif

endmodule
